pipe_reg_chain: RTL and testbench



---
 rtl/pipe_reg_chain.sv | 120 ++++++++++++
 tb/tb_pipe_reg_chain.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// Elastic chain of STAGES payload registers with valid/ready handshake, bubble collapse,
// partial flush of the youngest slots and an occupancy count. Optional skid entry: PIPE_REG_CHAIN_SKID_EN.
module pipe_reg_chain #(
   parameter int DATA_W = 32,
   parameter int STAGES = 4,
   parameter int IDX_W  = $clog2(STAGES),
   parameter int CNT_W  = $clog2(STAGES + 2)
) (
   input  logic              clockCPU,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   input  logic              flush,
   input  logic [IDX_W-1:0]  flush_upto,
   output logic [CNT_W-1:0]  count
);

   logic [STAGES-1:0] valid_reg;
   logic [DATA_W-1:0] data_reg [STAGES];
   logic [STAGES-1:0] squash;
   logic [STAGES-1:0] veff;
   logic [STAGES:0]   rdy;
   logic              accept;
   logic              src_valid;
   logic [DATA_W-1:0] src_data;
   logic [CNT_W-1:0]  count_sum;

   genvar gi;

   // A slot is ready when it is (effectively) empty or its successor is ready,
   // so an empty slot keeps accepting while everything downstream is stalled.
   assign rdy[STAGES] = out_ready;

   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_ready
         assign squash[gi] = flush & (IDX_W'(gi) <= flush_upto);
         assign veff[gi]   = valid_reg[gi] & ~squash[gi];
         assign rdy[gi]    = ~veff[gi] | rdy[gi+1];
      end
   endgenerate

`ifdef PIPE_REG_CHAIN_SKID_EN
   logic              skid_valid_reg;
   logic [DATA_W-1:0] skid_data_reg;

   // Registered ready: only the skid occupancy decides, never out_ready.
   assign in_ready  = ~skid_valid_reg & ~flush & reset;
   assign accept    = in_valid & in_ready;
   assign src_valid = skid_valid_reg ? ~flush : accept;
   assign src_data  = skid_valid_reg ? skid_data_reg : in_data;

   always_ff @(posedge clockCPU or negedge reset) begin
      if (!reset) begin
         skid_valid_reg <= 1'b0;
         skid_data_reg  <= '0;
      end else if (flush) begin
         skid_valid_reg <= 1'b0;
      end else if (skid_valid_reg && rdy[0]) begin
         skid_valid_reg <= 1'b0;
      end else if (accept && !rdy[0]) begin
         skid_valid_reg <= 1'b1;
         skid_data_reg  <= in_data;
      end
   end
`else
   assign in_ready  = rdy[0] & ~flush & reset;
   assign accept    = in_valid & in_ready;
   assign src_valid = accept;
   assign src_data  = in_data;
`endif

   always_ff @(posedge clockCPU or negedge reset) begin
      if (!reset) begin
         valid_reg <= '0;
         for (int i = 0; i < STAGES; i++) begin
            data_reg[i] <= '0;
         end
      end else begin
         if (rdy[0]) begin
            valid_reg[0] <= src_valid;
            if (src_valid) begin
               data_reg[0] <= src_data;
            end
         end else if (squash[0]) begin
            valid_reg[0] <= 1'b0;
         end
         for (int i = 1; i < STAGES; i++) begin
            if (rdy[i]) begin
               valid_reg[i] <= veff[i-1];
               if (veff[i-1]) begin
                  data_reg[i] <= data_reg[i-1];
               end
            end else if (squash[i]) begin
               valid_reg[i] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      count_sum = '0;
      for (int i = 0; i < STAGES; i++) begin
         count_sum = count_sum + CNT_W'(valid_reg[i]);
      end
   end

`ifdef PIPE_REG_CHAIN_SKID_EN
   assign count = count_sum + CNT_W'(skid_valid_reg);
`else
   assign count = count_sum;
`endif

   assign out_valid = valid_reg[STAGES-1];
   assign out_data  = data_reg[STAGES-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: directed scenarios plus random traffic checked against a
// queue-of-entries model where each entry carries its slot position.
`timescale 1ns/1ps
module tb_pipe_reg_chain;
   localparam int DW = 32;
   localparam int S  = 4;
   localparam int IW = 2;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic          flush;
   logic [IW-1:0] flush_upto;
   logic [CW-1:0] count;

   always #5 clk = ~clk;

   pipe_reg_chain #(.DATA_W(DW), .STAGES(S)) dut (
      .clockCPU  (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .flush     (flush),
      .flush_upto(flush_upto),
      .count     (count)
   );

   typedef struct {
      int          pos;
      logic [31:0] d;
   } ent_t;

   // Entries ordered oldest first; positions strictly decrease along the queue.
   ent_t        q[$];
   ent_t        nq[$];
   bit          skid_v, n_skid_v;
   logic [31:0] skid_d, n_skid_d;
   bit          exp_ir, exp_ov, exp_acc, exp_xfer;
   logic [31:0] exp_od;
   int          exp_cnt;
   int          n_assert = 0;
   int          n_fail   = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void compute(bit iv, logic [31:0] id, bit ordy, bit fl, int upto);
      int   lim;
      int   np;
      bit   free0;
      ent_t e;
      nq.delete();
      exp_ov   = (q.size() > 0) && (q[0].pos == S-1);
      exp_od   = exp_ov ? q[0].d : 32'h0;
      exp_cnt  = q.size() + int'(skid_v);
      exp_xfer = 1'b0;
      lim = S;
      for (int k = 0; k < q.size(); k++) begin
         if (fl && q[k].pos <= upto) continue;
         if (q[k].pos == S-1) begin
            if (ordy) begin
               exp_xfer = 1'b1;
               continue;
            end
            np = S-1;
         end else begin
            np = (q[k].pos + 1 < lim) ? q[k].pos + 1 : lim - 1;
         end
         lim   = np;
         e.pos = np;
         e.d   = q[k].d;
         nq.push_back(e);
      end
      free0    = (nq.size() == 0) || (nq[nq.size()-1].pos != 0);
      n_skid_v = skid_v;
      n_skid_d = skid_d;
      e.pos    = 0;
`ifdef PIPE_REG_CHAIN_SKID_EN
      exp_ir  = !skid_v && !fl;
      exp_acc = iv && exp_ir;
      if (free0) begin
         if (skid_v && !fl) begin
            e.d = skid_d;
            nq.push_back(e);
         end else if (exp_acc) begin
            e.d = id;
            nq.push_back(e);
         end
         n_skid_v = 1'b0;
      end else if (exp_acc) begin
         n_skid_v = 1'b1;
         n_skid_d = id;
      end else if (fl) begin
         n_skid_v = 1'b0;
      end
`else
      exp_ir  = free0 && !fl;
      exp_acc = iv && exp_ir;
      if (exp_acc) begin
         e.d = id;
         nq.push_back(e);
      end
`endif
   endfunction

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(bit iv, logic [31:0] id, bit ordy, bit fl, int upto);
      in_valid   = iv;
      in_data    = id;
      out_ready  = ordy;
      flush      = fl;
      flush_upto = IW'(upto);
      #1;
      compute(iv, id, ordy, fl, upto);
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("count", 32'(count), exp_cnt);
      if (exp_ov) chk("out_data", out_data, exp_od);
      $display("t=%0t in_v=%0b acc=%0b data=%08h flush=%0b/%0d out_xfer=%0b out_data=%08h count=%0d",
               $time, iv, exp_acc, id, fl, upto, exp_xfer, out_data, count);
      @(posedge clk);
      q      = nq;
      skid_v = n_skid_v;
      skid_d = n_skid_d;
      @(negedge clk);
   endtask

   task automatic idle(int n, bit ordy);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, ordy, 1'b0, 0);
   endtask

   task automatic model_clear();
      q.delete();
      skid_v = 1'b0;
      skid_d = 32'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      reset      = 1'b0;
      in_valid   = 1'b1;
      in_data    = 32'hDEAD_BEEF;
      out_ready  = 1'b1;
      flush      = 1'b0;
      flush_upto = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h0);

      // Stream three entries; first accept on the first cycle after release.
      @(negedge clk);
      reset = 1'b1;
      step(1'b1, 32'h11, 1'b1, 1'b0, 0);
      step(1'b1, 32'h22, 1'b1, 1'b0, 0);
      step(1'b1, 32'h33, 1'b1, 1'b0, 0);
      #1 chk("stream_peak_count", 32'(count), 32'd3);
      step(1'b0, 32'h0, 1'b1, 1'b0, 0);
      #1 chk("stream_latency_data", out_data, 32'h11);
      chk("stream_latency_valid", 32'(out_valid), 32'h1);
      idle(4, 1'b1);

      // Backpressure: six offers, four fit.
      for (int i = 0; i < 6; i++) step(1'b1, 32'hB0 + i, 1'b0, 1'b0, 0);
      #1 chk("bp_count", 32'(count), 32'd4);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      idle(6, 1'b1);
      #1 chk("bp_drained", 32'(count), 32'd0);

      // Bubble collapse: B catches up to A while the output is stalled.
      step(1'b1, 32'hA, 1'b0, 1'b0, 0);
      idle(2, 1'b0);
      step(1'b1, 32'hB, 1'b0, 1'b0, 0);
      idle(3, 1'b0);
      #1 chk("bubble_count", 32'(count), 32'd2);
      chk("bubble_out", out_data, 32'hA);
      idle(4, 1'b1);

      // Partial flush of slots 0..1 with a full, stalled chain.
      step(1'b1, 32'hD3, 1'b0, 1'b0, 0);
      step(1'b1, 32'hD2, 1'b0, 1'b0, 0);
      step(1'b1, 32'hD1, 1'b0, 1'b0, 0);
      step(1'b1, 32'hD0, 1'b0, 1'b0, 0);
      step(1'b1, 32'hEE, 1'b0, 1'b1, 1);
      #1 chk("pflush_count", 32'(count), 32'd2);
      chk("pflush_oldest", out_data, 32'hD3);
      idle(4, 1'b1);

      // Reset in mid-stream discards everything at once.
      for (int i = 0; i < 3; i++) step(1'b1, 32'hC0 + i, 1'b0, 1'b0, 0);
      idle(1, 1'b0);
      reset = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_count", 32'(count), 32'h0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      model_clear();
      step(1'b1, 32'hAA, 1'b1, 1'b0, 0);
      idle(3, 1'b1);
      #1 chk("post_rst_data", out_data, 32'hAA);
      idle(2, 1'b1);

`ifdef PIPE_REG_CHAIN_SKID_EN
      for (int i = 0; i < 5; i++) step(1'b1, 32'h50 + i, 1'b0, 1'b0, 0);
      #1 chk("skid_count", 32'(count), 32'd5);
      chk("skid_in_ready", 32'(in_ready), 32'h0);
      step(1'b0, 32'h0, 1'b0, 1'b1, 0);
      #1 chk("skid_flush_count", 32'(count), 32'd3);
      idle(6, 1'b1);
`endif

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
              $urandom_range(0, 9) == 0, int'($urandom_range(0, S-1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
